// File: rtl/firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv
// IJTAG test data register for the gate1 data-mux: drives mux select/override data
// from the update register and captures the observed mux output for readback.
module firebird7_in_gate1_tessent_tdr_data_mux_ctrl #(
   parameter int unsigned            WIDTH      = 3,
   parameter logic [WIDTH-1:0]       RESET_DATA = '0
) (
   input  logic             ijtag_tck,
   input  logic             ijtag_reset,
   input  logic             ijtag_sel,
   input  logic             ijtag_ce,
   input  logic             ijtag_se,
   input  logic             ijtag_ue,
   input  logic             ijtag_si,
   output logic             ijtag_so,
   input  logic [WIDTH-1:0] functional_data_in,
   output logic             ijtag_select,
   output logic [WIDTH-1:0] ijtag_data_in
);

   localparam int unsigned SR_W = WIDTH + 1;

   logic [SR_W-1:0] sr;
   logic [SR_W-1:0] ur;
   logic            so_r;

   // Capture/shift on the rising edge; capture wins, the current select is read back.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         sr <= '0;
      end else if (ijtag_sel && ijtag_ce) begin
         sr <= {ur[WIDTH], functional_data_in};
      end else if (ijtag_sel && ijtag_se) begin
         sr <= {ijtag_si, sr[SR_W-1:1]};
      end
   end

   // Update and scan-out retiming on the falling edge.
   always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         ur   <= {1'b0, RESET_DATA};
         so_r <= 1'b0;
      end else begin
         if (ijtag_sel && ijtag_ue) begin
            ur <= sr;
         end
         so_r <= sr[0];
      end
   end

   assign ijtag_so      = so_r;
   assign ijtag_select  = ur[WIDTH];
   assign ijtag_data_in = ur[WIDTH-1:0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv
// Self-checking bench for the gate1 data-mux TDR: directed scenarios plus
// randomized traffic checked against an integer-arithmetic reference model.
module tb_firebird7_in_gate1_tessent_tdr_data_mux_ctrl;

   localparam int unsigned W = 3;

   logic         ijtag_tck;
   logic         ijtag_reset;
   logic         ijtag_sel;
   logic         ijtag_ce;
   logic         ijtag_se;
   logic         ijtag_ue;
   logic         ijtag_si;
   logic         ijtag_so;
   logic [W-1:0] functional_data_in;
   logic         ijtag_select;
   logic [W-1:0] ijtag_data_in;

   int total = 0;
   int bad   = 0;

   // Reference model state: shift value, update value, scan-out bit
   int m_sr = 0;
   int m_ur = 0;
   int m_so = 0;

   // Outputs sampled just after the rising edge of the last cycle
   logic         mid_select;
   logic [W-1:0] mid_data;
   logic         mid_so;

   firebird7_in_gate1_tessent_tdr_data_mux_ctrl #(
      .WIDTH(W),
      .RESET_DATA(3'b000)
   ) dut (
      .ijtag_tck(ijtag_tck),
      .ijtag_reset(ijtag_reset),
      .ijtag_sel(ijtag_sel),
      .ijtag_ce(ijtag_ce),
      .ijtag_se(ijtag_se),
      .ijtag_ue(ijtag_ue),
      .ijtag_si(ijtag_si),
      .ijtag_so(ijtag_so),
      .functional_data_in(functional_data_in),
      .ijtag_select(ijtag_select),
      .ijtag_data_in(ijtag_data_in)
   );

   initial ijtag_tck = 1'b0;
   always #5 ijtag_tck = ~ijtag_tck;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One full TCK cycle; leaves the bench 1 time unit after the falling edge.
   task automatic cycle(input bit sel, input bit ce, input bit se, input bit ue,
                        input bit si, input int fdi);
      ijtag_sel          = sel;
      ijtag_ce           = ce;
      ijtag_se           = se;
      ijtag_ue           = ue;
      ijtag_si           = si;
      functional_data_in = W'(fdi);
      @(posedge ijtag_tck);
      if (sel && ce)
         m_sr = (((m_ur >> W) & 1) << W) | (fdi & ((1 << W) - 1));
      else if (sel && se)
         m_sr = (m_sr >> 1) | (int'(si) << W);
      #1;
      mid_select = ijtag_select;
      mid_data   = ijtag_data_in;
      mid_so     = ijtag_so;
      @(negedge ijtag_tck);
      if (sel && ue) m_ur = m_sr;
      m_so = m_sr & 1;
      #1;
   endtask

   task automatic model_reset();
      m_sr = 0;
      m_ur = 0;
      m_so = 0;
   endtask

   task automatic test_reset();
      ijtag_reset = 1'b0;
      ijtag_sel = 0; ijtag_ce = 0; ijtag_se = 0; ijtag_ue = 0; ijtag_si = 0;
      functional_data_in = '0;
      #1;
      total++;
      if (ijtag_select !== 1'b0 || ijtag_data_in !== 3'b000 || ijtag_so !== 1'b0) begin
         bad++;
         $display("FAIL reset_initial: sel=%b data=%b so=%b want 0/000/0",
                  ijtag_select, ijtag_data_in, ijtag_so);
      end
      @(negedge ijtag_tck); #1;
      ijtag_reset = 1'b1;
      model_reset();
      // Load all ones so the reset below has something to clear
      for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 1, 0);
      cycle(1, 0, 0, 1, 0, 0);
      total++;
      if (ijtag_select !== 1'b1 || ijtag_data_in !== 3'b111 || ijtag_so !== 1'b1) begin
         bad++;
         $display("FAIL reset_preload: sel=%b data=%b so=%b want 1/111/1",
                  ijtag_select, ijtag_data_in, ijtag_so);
      end
      @(posedge ijtag_tck); #2;
      ijtag_reset = 1'b0;
      #1;
      total++;
      if (ijtag_select !== 1'b0 || ijtag_data_in !== 3'b000 || ijtag_so !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: sel=%b data=%b so=%b want 0/000/0",
                  ijtag_select, ijtag_data_in, ijtag_so);
      end
      model_reset();
      @(negedge ijtag_tck); #1;
      ijtag_reset = 1'b1;
   endtask

   task automatic test_load_override();
      bit bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 1, 0, bits[i], 0);
         total++;
         if (ijtag_select !== 1'b0 || ijtag_data_in !== 3'b000) begin
            bad++;
            $display("FAIL load_shift%0d: sel=%b data=%b want 0/000", i,
                     ijtag_select, ijtag_data_in);
         end
      end
      total++;
      if (dut.sr !== 4'b1101) begin
         bad++;
         $display("FAIL load_sr: sr=%b want 1101", dut.sr);
      end
      cycle(1, 0, 0, 1, 0, 0);
      total++;
      if (mid_select !== 1'b0 || mid_data !== 3'b000) begin
         bad++;
         $display("FAIL load_early: sel=%b data=%b before falling edge want 0/000",
                  mid_select, mid_data);
      end
      total++;
      if (ijtag_select !== 1'b1 || ijtag_data_in !== 3'b101) begin
         bad++;
         $display("FAIL load_update: sel=%b data=%b want 1/101", ijtag_select, ijtag_data_in);
      end
   endtask

   task automatic test_capture_readback();
      bit exp_so [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      cycle(1, 1, 0, 0, 0, 3);
      total++;
      if (ijtag_so !== exp_so[0]) begin
         bad++;
         $display("FAIL capture_so0: so=%b want %b", ijtag_so, exp_so[0]);
      end
      for (int i = 1; i < 5; i++) begin
         cycle(1, 0, 1, 0, 0, 0);
         total++;
         if (ijtag_so !== exp_so[i] || ijtag_select !== 1'b1 || ijtag_data_in !== 3'b101) begin
            bad++;
            $display("FAIL capture_so%0d: so=%b sel=%b data=%b want %b/1/101", i,
                     ijtag_so, ijtag_select, ijtag_data_in, exp_so[i]);
         end
      end
   endtask

   task automatic test_priority_deselect();
      cycle(1, 1, 1, 0, 1, 6);
      total++;
      if (dut.sr !== 4'b1110) begin
         bad++;
         $display("FAIL priority_capture: sr=%b want 1110", dut.sr);
      end
      for (int i = 0; i < 8; i++) begin
         cycle(0, bit'($urandom), bit'($urandom), bit'($urandom), bit'($urandom),
               int'($urandom_range(0, 7)));
         total++;
         if (dut.sr !== 4'b1110 || ijtag_select !== 1'b1 || ijtag_data_in !== 3'b101 ||
             ijtag_so !== 1'b0) begin
            bad++;
            $display("FAIL deselect%0d: sr=%b sel=%b data=%b so=%b want 1110/1/101/0", i,
                     dut.sr, ijtag_select, ijtag_data_in, ijtag_so);
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      cycle(1, 0, 1, 0, 1, 0);
      cycle(1, 0, 1, 0, 1, 0);
      #1;
      ijtag_reset = 1'b0;
      #1;
      total++;
      if (dut.sr !== 4'b0000 || ijtag_select !== 1'b0 || ijtag_so !== 1'b0) begin
         bad++;
         $display("FAIL midshift_reset: sr=%b sel=%b so=%b want 0000/0/0",
                  dut.sr, ijtag_select, ijtag_so);
      end
      #1;
      ijtag_reset = 1'b1;
      model_reset();
      cycle(1, 0, 0, 1, 0, 0);
      total++;
      if (ijtag_select !== 1'b0 || ijtag_data_in !== 3'b000) begin
         bad++;
         $display("FAIL midshift_update: sel=%b data=%b want 0/000", ijtag_select, ijtag_data_in);
      end
   endtask

   task automatic test_random();
      int exp_sel;
      int exp_data;
      int pre_sel;
      int pre_data;
      int pre_so;
      for (int i = 0; i < 400; i++) begin
         pre_sel  = (m_ur >> W) & 1;
         pre_data = m_ur & ((1 << W) - 1);
         pre_so   = m_so;
         cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), bit'($urandom),
               ($urandom_range(0, 3) == 0), bit'($urandom), int'($urandom_range(0, 7)));
         exp_sel  = (m_ur >> W) & 1;
         exp_data = m_ur & ((1 << W) - 1);
         total++;
         if (mid_select !== 1'(pre_sel) || mid_data !== W'(pre_data) || mid_so !== 1'(pre_so)) begin
            bad++;
            $display("FAIL rand_rise%0d: sel=%b data=%b so=%b want %0d/%0d/%0d", i,
                     mid_select, mid_data, mid_so, pre_sel, pre_data, pre_so);
         end
         total++;
         if (ijtag_select !== 1'(exp_sel) || ijtag_data_in !== W'(exp_data) ||
             ijtag_so !== 1'(m_so)) begin
            bad++;
            $display("FAIL rand_fall%0d: sel=%b data=%b so=%b want %0d/%0d/%0d", i,
                     ijtag_select, ijtag_data_in, ijtag_so, exp_sel, exp_data, m_so);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_override();
      test_capture_readback();
      test_priority_deselect();
      test_reset_mid_shift();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
